// File: rtl/mspe_pkg.sv
// Shared types, defaults and header rules for the multi-source packet merger.
package mspe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam int DEF_DATA_W  = 512;
  localparam int DEF_COUNT_W = 32;
  localparam int DEF_MAX_LEN = 256;

  // Lengths are widened to 64 bits so one function serves any COUNT_W up to 64.
  function automatic logic hdr_ok(input logic [63:0] len, input logic [63:0] max_len);
    return (len != 64'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/mspe_rr_pick.sv
// Combinational round-robin finder: first set request at or above ptr, with wrap.
module mspe_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int c;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mspe_src_merge.sv
// Merges length-prefixed packets from CHANNELS FWFT FIFOs onto one Avalon-ST
// source; headers are consumed, payload is forwarded whole, round-robin per packet.
module mspe_src_merge
  import mspe_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int COUNT_W  = DEF_COUNT_W,
  parameter int MAX_LEN  = DEF_MAX_LEN
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS*DATA_W-1:0]  ch_data,
  input  logic [CHANNELS*COUNT_W-1:0] ch_count,
  output logic [CHANNELS-1:0]         ch_re,
  input  logic [CHANNELS-1:0]         ch_enable,
  output logic [DATA_W-1:0]           src_data,
  output logic                        src_valid,
  output logic                        src_sop,
  output logic                        src_eop,
  input  logic                        src_ready,
  output logic                        busy,
  output logic                        err_pulse,
  output logic [3:0]                  err_channel
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t               state, state_n;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        g;
  logic [COUNT_W-1:0]   remaining;
  logic                 first;

  logic [COUNT_W-1:0]   hdr_len [CHANNELS];
  logic [CHANNELS-1:0]  bad, room, cand;
  logic [IW-1:0]        pick;
  logic                 pick_found;
  logic                 load;
  logic                 last;
  logic [DATA_W-1:0]    cur_data;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (int'(x) == CHANNELS - 1) ? '0 : x + 1'b1;
  endfunction

  // Room compare is one bit wider than the count so L = 2^COUNT_W-1 cannot wrap.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_cand
    assign hdr_len[c] = ch_data[c*DATA_W +: COUNT_W];
    assign bad[c]     = !hdr_ok(64'(hdr_len[c]), 64'(MAX_LEN));
    assign room[c]    = {1'b0, ch_count[c*COUNT_W +: COUNT_W]} >=
                        ({1'b0, hdr_len[c]} + {{COUNT_W{1'b0}}, 1'b1});
    assign cand[c]    = ch_enable[c] && (ch_count[c*COUNT_W +: COUNT_W] != '0) &&
                        (bad[c] || room[c]);
  end

  mspe_rr_pick #(.N(CHANNELS), .IW(IW)) u_pick (
    .req   (cand),
    .ptr   (rr_ptr),
    .idx   (pick),
    .found (pick_found)
  );

  assign cur_data = ch_data[int'(g)*DATA_W +: DATA_W];
  assign load     = (state == DATA) && (!src_valid || src_ready);
  assign last     = (remaining == COUNT_W'(1));
  assign busy     = (state != IDLE) || src_valid;

  always_comb begin
    state_n = state;
    ch_re   = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            ch_re[pick] = 1'b1;
            if (!bad[pick]) state_n = DATA;
          end
        end
        DATA: begin
          if (load) begin
            ch_re[g] = 1'b1;
            if (last) state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      g           <= '0;
      remaining   <= '0;
      first       <= 1'b0;
      src_data    <= '0;
      src_valid   <= 1'b0;
      src_sop     <= 1'b0;
      src_eop     <= 1'b0;
      err_pulse   <= 1'b0;
      err_channel <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // The last word of the previous packet may still be waiting for the sink.
          if (src_valid && src_ready) src_valid <= 1'b0;
          if (pick_found) begin
            if (bad[pick]) begin
              err_pulse   <= 1'b1;
              err_channel <= 4'(pick);
              rr_ptr      <= inc(pick);
            end else begin
              g         <= pick;
              remaining <= hdr_len[pick];
              first     <= 1'b1;
            end
          end
        end
        DATA: begin
          if (load) begin
            src_data  <= cur_data;
            src_valid <= 1'b1;
            src_sop   <= first;
            src_eop   <= last;
            first     <= 1'b0;
            remaining <= remaining - COUNT_W'(1);
            if (last) rr_ptr <= inc(g);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
